// File: rtl/intr_controller_prio.sv
// intr_controller_prio: prioritised interrupt controller with enable, level/edge mode, pending, claim/complete
// Optional feature macro: IRQ_SYNC_EN adds a 2-flop synchroniser on irq_source (latency 4 instead of 2).
// Ports:
//   clk, rst (sync, active-low)
//   data_req/we/be/addr/wdata -> data_gnt/rvalid/rdata : core data bus slave at data_addr[31:12]==BASE_HI
//   irq_source[N_SRC]          : raw active-high interrupt lines
//   intr_id, intr_signal       : registered highest-priority active id (16'hFFFF if none) and request
module intr_controller_prio #(
    parameter int          N_SRC   = 256,
    parameter logic [19:0] BASE_HI = 20'h00022
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_req,
    input  logic             data_we,
    input  logic [3:0]       data_be,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_gnt,
    output logic             data_rvalid,
    output logic [31:0]      data_rdata,
    input  logic [N_SRC-1:0] irq_source,
    output logic [15:0]      intr_id,
    output logic             intr_signal
);
    localparam int NW = N_SRC / 32;
    localparam int CW = $clog2(N_SRC + 1);
    localparam logic [N_SRC-1:0] ONE = N_SRC'(1);
    logic [N_SRC-1:0] irq_in, irq_s, irq_p, en, mode, pend, inserv;
    logic [N_SRC-1:0] rise, pend_vis, active, wmask, wdat, claim_m, comp_m, w1c_m;
    logic [CW-1:0]    cnt;
    logic [15:0]      id_nxt;
    logic [11:0]      off;
    logic [10:0]      sh;
    logic [31:0]      bm, rword;
    logic             acc, wr, rd, wv, claim, claim_new, comp;
`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1, sync2;
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_source;
            sync2 <= sync1;
        end
    end
    assign irq_in = sync2;
`else
    assign irq_in = irq_source;
`endif
    assign off   = data_addr[11:0];
    assign acc   = data_req & (data_addr[31:12] == BASE_HI) & ~data_gnt;
    assign wr    = acc & data_we;
    assign rd    = acc & ~data_we;
    // misaligned addresses are treated as unmapped
    assign wv    = (off[1:0] == 2'b00) && ({26'd0, off[7:2]} < 32'(NW));
    assign sh    = {off[7:2], 5'd0};
    assign bm    = {{8{data_be[3]}}, {8{data_be[2]}}, {8{data_be[1]}}, {8{data_be[0]}}};
    assign wmask = wv ? (N_SRC'(bm) << sh) : '0;
    assign wdat  = N_SRC'(data_wdata) << sh;
    // edge pending includes the rise seen this cycle so edge and level sources share the same latency
    assign rise     = irq_s & ~irq_p;
    assign pend_vis = (mode & (pend | rise)) | (~mode & irq_s);
    assign active   = pend_vis & en & ~inserv;
    // claim uses the registered id the core has already observed
    assign claim     = rd && off == 12'h300 && intr_id != 16'hFFFF;
    assign claim_m   = claim ? ONE << intr_id : '0;
    assign claim_new = |(claim_m & ~inserv);
    // out-of-range ids shift out to zero; ids not in service are masked off
    assign comp_m = (wr && off == 12'h300) ? (ONE << data_wdata[15:0]) & inserv : '0;
    assign comp   = |comp_m;
    assign w1c_m  = (wr && off[11:8] == 4'h2) ? wmask & wdat : '0;
    assign rword = (off[11:8] == 4'h0 && wv) ? 32'(en >> sh) :
                   (off[11:8] == 4'h1 && wv) ? 32'(mode >> sh) :
                   (off[11:8] == 4'h2 && wv) ? 32'(pend_vis >> sh) :
                   (off == 12'h300) ? {16'd0, intr_id} :
                   (off == 12'h304) ? 32'(cnt) : '0;
    always_comb begin
        id_nxt = 16'hFFFF;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (active[i]) id_nxt = 16'(i);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_s       <= '0;
            irq_p       <= '0;
            en          <= '0;
            mode        <= '0;
            pend        <= '0;
            inserv      <= '0;
            cnt         <= '0;
            data_gnt    <= 1'b0;
            data_rvalid <= 1'b0;
            data_rdata  <= '0;
            intr_signal <= 1'b0;
            intr_id     <= 16'hFFFF;
        end else begin
            irq_s       <= irq_in;
            irq_p       <= irq_s;
            data_gnt    <= acc;
            data_rvalid <= data_gnt;
            if (acc) data_rdata <= rword;
            if (wr && off[11:8] == 4'h0) en <= (en & ~wmask) | (wdat & wmask);
            if (wr && off[11:8] == 4'h1) mode <= (mode & ~wmask) | (wdat & wmask);
            // a new edge overrides a same-cycle clear; level bits never latch
            pend        <= mode & ((pend & ~w1c_m & ~claim_m) | rise);
            inserv      <= (inserv | claim_m) & ~comp_m;
            cnt         <= cnt + CW'(claim_new) - CW'(comp);
            intr_signal <= |active;
            intr_id     <= id_nxt;
        end
    end
endmodule

// File: tb/tb_intr_controller_prio.sv
// tb_intr_controller_prio: directed bench for intr_controller_prio (N_SRC=256 and N_SRC=64 instances)
module tb_intr_controller_prio;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         data_req = 1'b0, data_we = 1'b0;
    logic [3:0]   data_be = 4'h0;
    logic [31:0]  data_addr = '0, data_wdata = '0;
    logic         gnt, rvalid, gnt64, rvalid64, sig, sig64;
    logic [31:0]  rdata, rdata64;
    logic [15:0]  id, id64;
    logic [255:0] irq = '0;
    logic [63:0]  irq64 = '0;
    logic [31:0]  r, r64;
    int           checks = 0, errors = 0, g;
    localparam logic [31:0] B = 32'h0002_2000;

    typedef struct {
        logic        we;
        logic [11:0] off;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t v[19];

    always #5 clk = ~clk;

    intr_controller_prio u_dut (
        .clk(clk), .rst(rst), .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(gnt), .data_rvalid(rvalid),
        .data_rdata(rdata), .irq_source(irq), .intr_id(id), .intr_signal(sig)
    );

    intr_controller_prio #(.N_SRC(64)) u_d64 (
        .clk(clk), .rst(rst), .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(gnt64), .data_rvalid(rvalid64),
        .data_rdata(rdata64), .irq_source(irq64), .intr_id(id64), .intr_signal(sig64)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [11:0] off, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic [31:0] rd64);
        int n;
        n = 0;
        rd = '0;
        rd64 = '0;
        @(negedge clk);
        data_req = 1'b1; data_we = we; data_addr = B | 32'(off); data_wdata = wd; data_be = be;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!gnt && n < 16);
        data_req = 1'b0;
        if (!gnt) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout off=%h no grant within 16 cycles", off);
        end else begin
            @(posedge clk); #1;
            chk("rvalid", 32'(rvalid), 32'd1);
            rd = rdata;
            rd64 = rdata64;
        end
    endtask

    initial begin
        v[0]  = '{1'b0, 12'h000, 32'h0,         4'h0, 32'h0};
        v[1]  = '{1'b0, 12'h100, 32'h0,         4'h0, 32'h0};
        v[2]  = '{1'b0, 12'h200, 32'h0,         4'h0, 32'h0};
        v[3]  = '{1'b0, 12'h300, 32'h0,         4'h0, 32'h0000_FFFF};
        v[4]  = '{1'b0, 12'h304, 32'h0,         4'h0, 32'h0};
        v[5]  = '{1'b1, 12'h004, 32'hA5A5_A5A5, 4'h5, 32'h0};
        v[6]  = '{1'b0, 12'h004, 32'h0,         4'h0, 32'h00A5_00A5};
        v[7]  = '{1'b1, 12'h004, 32'hFFFF_FFFF, 4'h8, 32'h0};
        v[8]  = '{1'b0, 12'h004, 32'h0,         4'h0, 32'hFFA5_00A5};
        v[9]  = '{1'b1, 12'h104, 32'h1234_5678, 4'hF, 32'h0};
        v[10] = '{1'b0, 12'h104, 32'h0,         4'h0, 32'h1234_5678};
        v[11] = '{1'b1, 12'h020, 32'hFFFF_FFFF, 4'hF, 32'h0};
        v[12] = '{1'b0, 12'h020, 32'h0,         4'h0, 32'h0};
        v[13] = '{1'b0, 12'h01C, 32'h0,         4'h0, 32'h0};
        v[14] = '{1'b0, 12'h400, 32'h0,         4'h0, 32'h0};
        v[15] = '{1'b0, 12'h308, 32'h0,         4'h0, 32'h0};
        v[16] = '{1'b1, 12'h004, 32'h0,         4'hF, 32'h0};
        v[17] = '{1'b1, 12'h104, 32'h0,         4'hF, 32'h0};
        v[18] = '{1'b0, 12'h004, 32'h0,         4'h0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sig", 32'(sig), 32'd0);
        chk("rst_id", 32'(id), 32'h0000_FFFF);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_id64", 32'(id64), 32'h0000_FFFF);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            bus(v[i].we, v[i].off, v[i].wd, v[i].be, r, r64);
            if (!v[i].we) chk($sformatf("vec%0d_off%h", i, v[i].off), r, v[i].exp);
        end

        // bus outside the decoded page is never granted
        g = 0;
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0002_3004; data_wdata = '1; data_be = 4'hF;
        repeat (4) begin @(posedge clk); #1; g += int'(gnt); end
        data_req = 1'b0;
        chk("nodecode_grants", 32'(g), 32'd0);
        bus(1'b0, 12'h004, 32'h0, 4'h0, r, r64);
        chk("nodecode_no_write", r, 32'h0);

        // request held high: grant every other cycle
        g = 0;
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b0; data_addr = B; data_be = 4'h0;
        repeat (4) begin @(posedge clk); #1; g += int'(gnt); end
        data_req = 1'b0;
        repeat (2) @(posedge clk);
        chk("b2b_grants", 32'(g), 32'd2);

        // level sources 4 and 5
        bus(1'b1, 12'h000, 32'h30, 4'hF, r, r64);
        @(negedge clk);
        irq[4] = 1'b1;
        irq[5] = 1'b1;
        @(posedge clk); #1;
        chk("lvl_lat1_sig", 32'(sig), 32'd0);
        @(posedge clk); #1;
        chk("lvl_lat2_sig", 32'(sig), 32'd1);
        chk("lvl_id", 32'(id), 32'd4);
        bus(1'b0, 12'h300, 32'h0, 4'h0, r, r64);
        chk("claim4", r, 32'd4);
        chk("id_after_claim4", 32'(id), 32'd5);
        bus(1'b0, 12'h304, 32'h0, 4'h0, r, r64);
        chk("cnt1", r, 32'd1);
        bus(1'b0, 12'h300, 32'h0, 4'h0, r, r64);
        chk("claim5", r, 32'd5);
        bus(1'b0, 12'h304, 32'h0, 4'h0, r, r64);
        chk("cnt2", r, 32'd2);
        chk("all_inserv_sig", 32'(sig), 32'd0);
        chk("all_inserv_id", 32'(id), 32'h0000_FFFF);
        bus(1'b0, 12'h300, 32'h0, 4'h0, r, r64);
        chk("claim_none", r, 32'h0000_FFFF);
        bus(1'b1, 12'h300, 32'd9, 4'hF, r, r64);
        bus(1'b1, 12'h300, 32'h104, 4'hF, r, r64);
        bus(1'b0, 12'h304, 32'h0, 4'h0, r, r64);
        chk("bogus_complete_cnt", r, 32'd2);
        bus(1'b1, 12'h300, 32'd5, 4'hF, r, r64);
        bus(1'b0, 12'h304, 32'h0, 4'h0, r, r64);
        chk("complete5_cnt", r, 32'd1);
        chk("refire5_id", 32'(id), 32'd5);
        bus(1'b1, 12'h300, 32'd4, 4'hF, r, r64);
        bus(1'b0, 12'h304, 32'h0, 4'h0, r, r64);
        chk("complete4_cnt", r, 32'd0);
        chk("refire4_id", 32'(id), 32'd4);
        @(negedge clk);
        irq[4] = 1'b0;
        irq[5] = 1'b0;
        bus(1'b1, 12'h000, 32'h0, 4'hF, r, r64);
        chk("lvl_clear_sig", 32'(sig), 32'd0);

        // edge source 7
        bus(1'b1, 12'h100, 32'h80, 4'hF, r, r64);
        bus(1'b1, 12'h000, 32'h80, 4'hF, r, r64);
        @(negedge clk) irq[7] = 1'b1;
        @(posedge clk); #1;
        chk("edge_lat1_sig", 32'(sig), 32'd0);
        @(negedge clk) irq[7] = 1'b0;
        @(posedge clk); #1;
        chk("edge_lat2_sig", 32'(sig), 32'd1);
        chk("edge_id", 32'(id), 32'd7);
        bus(1'b0, 12'h200, 32'h0, 4'h0, r, r64);
        chk("edge_pend_latched", r, 32'h80);
        bus(1'b1, 12'h200, 32'h80, 4'hF, r, r64);
        bus(1'b0, 12'h200, 32'h0, 4'h0, r, r64);
        chk("edge_w1c", r, 32'h0);
        chk("edge_w1c_sig", 32'(sig), 32'd0);
        @(negedge clk) irq[7] = 1'b1;
        @(negedge clk) irq[7] = 1'b0;
        bus(1'b0, 12'h300, 32'h0, 4'h0, r, r64);
        chk("claim7", r, 32'd7);
        bus(1'b0, 12'h200, 32'h0, 4'h0, r, r64);
        chk("claim7_pend", r, 32'h0);
        bus(1'b0, 12'h304, 32'h0, 4'h0, r, r64);
        chk("claim7_cnt", r, 32'd1);
        bus(1'b1, 12'h300, 32'd7, 4'hF, r, r64);
        bus(1'b0, 12'h304, 32'h0, 4'h0, r, r64);
        chk("complete7_cnt", r, 32'd0);
        chk("edge_no_refire", 32'(sig), 32'd0);

        // edge set on the same edge as W1C of that bit
        @(negedge clk) irq[7] = 1'b1;
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = B | 32'h200; data_wdata = 32'h80; data_be = 4'hF;
        @(posedge clk); #1;
        chk("setwin_gnt", 32'(gnt), 32'd1);
        data_req = 1'b0;
        @(negedge clk) irq[7] = 1'b0;
        bus(1'b0, 12'h200, 32'h0, 4'h0, r, r64);
        chk("setwin_pend", r, 32'h80);
        bus(1'b1, 12'h200, 32'h80, 4'hF, r, r64);
        bus(1'b0, 12'h200, 32'h0, 4'h0, r, r64);
        chk("setwin_cleanup", r, 32'h0);

        // reset in the middle of an access
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b0; data_addr = B; data_be = 4'h0;
        @(posedge clk); #1;
        chk("midrst_gnt", 32'(gnt), 32'd1);
        data_req = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_gnt_drop", 32'(gnt), 32'd0);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk) rst = 1'b1;
        bus(1'b0, 12'h000, 32'h0, 4'h0, r, r64);
        chk("midrst_en", r, 32'h0);
        bus(1'b0, 12'h100, 32'h0, 4'h0, r, r64);
        chk("midrst_mode", r, 32'h0);

        // 64-source instance
        bus(1'b1, 12'h004, 32'h100, 4'hF, r, r64);
        @(negedge clk);
        irq64[40] = 1'b1;
        irq64[63] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("n64_id", 32'(id64), 32'd40);
        chk("n64_sig", 32'(sig64), 32'd1);
        bus(1'b0, 12'h204, 32'h0, 4'h0, r, r64);
        chk("n64_pend1", r64, 32'h8000_0100);
        bus(1'b0, 12'h004, 32'h0, 4'h0, r, r64);
        chk("n64_en1", r64, 32'h100);
        bus(1'b0, 12'h208, 32'h0, 4'h0, r, r64);
        chk("n64_pend2_unmapped", r64, 32'h0);
        bus(1'b0, 12'h10C, 32'h0, 4'h0, r, r64);
        chk("n64_mode3_unmapped", r64, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
